// File: rtl/legv8_pkg.sv
// Shared definitions for the multi-cycle LEGv8 controller: opcode patterns,
// ALU codes, FSM states, instruction classes and exception codes.
package legv8_pkg;

  localparam int OP_W   = 11;
  localparam int ALUC_W = 4;

  // Full 11-bit opcodes
  localparam logic [OP_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OP_W-1:0] OP_STUR = 11'b11111000000;
  localparam logic [OP_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OP_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OP_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OP_W-1:0] OP_ORR  = 11'b10101010000;

  // Branches only match on the upper 8 bits; the low 3 bits are don't-care
  localparam logic [7:0] OP_CBZ_PFX   = 8'b10110100;
  localparam logic [7:0] OP_BCOND_PFX = 8'b01010100;

  // ALU control codes
  localparam logic [ALUC_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_ORR = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_CBZ = 4'b0111;

  // Exception codes
  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_INVALID = 2'b01;
  localparam logic [1:0] EXC_FETCH   = 2'b10;
  localparam logic [1:0] EXC_DATA    = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_EXC    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    IC_R       = 3'd0,
    IC_LOAD    = 3'd1,
    IC_STORE   = 3'd2,
    IC_CBZ     = 3'd3,
    IC_BCOND   = 3'd4,
    IC_INVALID = 3'd5
  } iclass_t;

endpackage

// File: rtl/instr_classifier.sv
// Combinational opcode decoder: maps the 11-bit opcode to an instruction
// class and the ALU operation that class needs.
module instr_classifier
  import legv8_pkg::*;
(
  input  logic [OP_W-1:0]   instr,
  output iclass_t           iclass,
  output logic [ALUC_W-1:0] aluc
);

  // Exact matches first, then prefix matches for the two branch forms
  always_comb begin
    iclass = IC_INVALID;
    aluc   = ALU_AND;
    if (instr == OP_LDUR) begin
      iclass = IC_LOAD;
      aluc   = ALU_ADD;
    end else if (instr == OP_STUR) begin
      iclass = IC_STORE;
      aluc   = ALU_ADD;
    end else if (instr == OP_ADD) begin
      iclass = IC_R;
      aluc   = ALU_ADD;
    end else if (instr == OP_SUB) begin
      iclass = IC_R;
      aluc   = ALU_SUB;
    end else if (instr == OP_AND) begin
      iclass = IC_R;
      aluc   = ALU_AND;
    end else if (instr == OP_ORR) begin
      iclass = IC_R;
      aluc   = ALU_ORR;
    end else if (instr[OP_W-1:3] == OP_CBZ_PFX) begin
      iclass = IC_CBZ;
      aluc   = ALU_CBZ;
    end else if (instr[OP_W-1:3] == OP_BCOND_PFX) begin
      iclass = IC_BCOND;
      aluc   = ALU_CBZ;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle LEGv8 control FSM. Sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared datapath, waits on a variable-latency memory with a watchdog, and
// parks in a sticky EXC state on invalid opcodes or memory timeouts.
//
// Memory handshake: in FETCH and MEM the controller holds its request
// (memRead or memWrite, plus i_or_d) every cycle until mem_ready is seen high
// at a rising edge; that edge completes the transfer. mem_ready in any other
// state is ignored.
module multicycle_controller
  import legv8_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   instr,
  input  logic              mem_ready,
  output logic [ALUC_W-1:0] AluControl,
  output logic              ir_write,
  output logic              pc_write,
  output logic              i_or_d,
  output logic              reg2loc,
  output logic              AluSrc,
  output logic              memtoReg,
  output logic              Branch,
  output logic              CondCheck,
  output logic              memRead,
  output logic              memWrite,
  output logic              regWrite,
  output logic              exc,
  output logic [1:0]        exc_code,
  output logic [2:0]        state_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MEM_TIMEOUT);

  state_t            state;
  iclass_t           iclass_q;
  logic [ALUC_W-1:0] aluc_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [1:0]        code_q;

  iclass_t           dec_class;
  logic [ALUC_W-1:0] dec_aluc;

  instr_classifier u_classifier (
    .instr  (instr),
    .iclass (dec_class),
    .aluc   (dec_aluc)
  );

  // State sequencing, class/ALU latch, wait counter and exception code
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FETCH;
      iclass_q <= IC_R;
      aluc_q   <= ALU_AND;
      wait_cnt <= '0;
      code_q   <= EXC_NONE;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            state <= ST_DECODE;
          end else if (wait_cnt == CNT_LAST) begin
            // a late mem_ready in this same cycle would have won above
            state    <= ST_EXC;
            code_q   <= EXC_FETCH;
            wait_cnt <= CNT_SAT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DECODE: begin
          iclass_q <= dec_class;
          aluc_q   <= dec_aluc;
          if (dec_class == IC_INVALID) begin
            state  <= ST_EXC;
            code_q <= EXC_INVALID;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (iclass_q)
            IC_LOAD, IC_STORE: begin
              state    <= ST_MEM;
              wait_cnt <= '0;
            end
            IC_CBZ, IC_BCOND: begin
              state    <= ST_FETCH;
              wait_cnt <= '0;
            end
            default: state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (iclass_q == IC_LOAD) begin
              state <= ST_WB;
            end else begin
              state    <= ST_FETCH;
              wait_cnt <= '0;
            end
          end else if (wait_cnt == CNT_LAST) begin
            state    <= ST_EXC;
            code_q   <= EXC_DATA;
            wait_cnt <= CNT_SAT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_WB: begin
          state    <= ST_FETCH;
          wait_cnt <= '0;
        end
        ST_EXC: begin
          state <= ST_EXC;
        end
        default: begin
          state    <= ST_FETCH;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Strobe decode from state and latched class; forced low while reset is
  // asserted so an interrupted MEM never leaks a partial write.
  // reg2loc in DECODE uses the live classification because the register
  // read happens in the same cycle the class is being latched.
  always_comb begin
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    i_or_d    = 1'b0;
    reg2loc   = 1'b0;
    AluSrc    = 1'b0;
    memtoReg  = 1'b0;
    Branch    = 1'b0;
    CondCheck = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          memRead  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        ST_DECODE: begin
          reg2loc = (dec_class == IC_STORE) || (dec_class == IC_CBZ);
        end
        ST_EXEC: begin
          AluSrc    = (iclass_q == IC_LOAD) || (iclass_q == IC_STORE);
          Branch    = (iclass_q == IC_CBZ) || (iclass_q == IC_BCOND);
          CondCheck = (iclass_q == IC_BCOND);
        end
        ST_MEM: begin
          i_or_d   = 1'b1;
          memRead  = (iclass_q == IC_LOAD);
          memWrite = (iclass_q == IC_STORE);
        end
        ST_WB: begin
          regWrite = 1'b1;
          memtoReg = (iclass_q == IC_LOAD);
        end
        default: ;
      endcase
    end
  end

  assign AluControl = aluc_q;
  assign exc        = (state == ST_EXC);
  assign exc_code   = code_q;
  assign state_o    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a vector table walking every
// instruction class, plus hand-written sequences for timeouts, invalid
// opcodes and reset in the middle of an instruction.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [10:0] instr;
  logic        mem_ready;
  logic [3:0]  AluControl;
  logic        ir_write, pc_write, i_or_d, reg2loc, AluSrc, memtoReg;
  logic        Branch, CondCheck, memRead, memWrite, regWrite;
  logic        exc;
  logic [1:0]  exc_code;
  logic [2:0]  state_o;

  multicycle_controller #(.MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .mem_ready  (mem_ready),
    .AluControl (AluControl),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .i_or_d     (i_or_d),
    .reg2loc    (reg2loc),
    .AluSrc     (AluSrc),
    .memtoReg   (memtoReg),
    .Branch     (Branch),
    .CondCheck  (CondCheck),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .regWrite   (regWrite),
    .exc        (exc),
    .exc_code   (exc_code),
    .state_o    (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, SX = 3'd5;

  // strobe vector bit order: ir_write pc_write i_or_d reg2loc AluSrc memtoReg
  //                          Branch CondCheck memRead memWrite regWrite
  localparam logic [10:0] B_IR = 11'h400, B_PC = 11'h200, B_IOD = 11'h100, B_R2L = 11'h080;
  localparam logic [10:0] B_ASRC = 11'h040, B_M2R = 11'h020, B_BR = 11'h010, B_CC = 11'h008;
  localparam logic [10:0] B_MR = 11'h004, B_MW = 11'h002, B_RW = 11'h001;
  localparam logic [10:0] FRDY = B_IR | B_PC | B_MR;
  localparam logic [10:0] NONE = 11'h000;

  localparam logic [10:0] I_LDUR = 11'b11111000010;
  localparam logic [10:0] I_STUR = 11'b11111000000;
  localparam logic [10:0] I_ADD  = 11'b10001011000;
  localparam logic [10:0] I_SUB  = 11'b11001011000;
  localparam logic [10:0] I_AND  = 11'b10001010000;
  localparam logic [10:0] I_ORR  = 11'b10101010000;
  localparam logic [10:0] I_CBZ  = 11'b10110100101;
  localparam logic [10:0] I_BC   = 11'b01010100011;
  localparam logic [10:0] I_BAD  = 11'b00000000000;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [10:0] ins;
    logic [2:0]  st;
    logic [10:0] str;
    logic        ex;
    logic [1:0]  code;
    logic        chk_alu;
    logic [3:0]  alu;
  } vec_t;

  localparam int NV = 37;
  vec_t tbl [NV];

  int total = 0;
  int bad   = 0;

  // regWrite monitor for the interrupted-load sequence
  logic mon_en  = 1'b0;
  logic rw_seen = 1'b0;
  always @(negedge clk) if (mon_en && regWrite) rw_seen <= 1'b1;

  // scoreboard compare of one sampled cycle
  task automatic check(input string name, input logic [2:0] st, input logic [10:0] str,
                       input logic ex, input logic [1:0] code, input logic chk_alu,
                       input logic [3:0] alu);
    logic [10:0] act;
    logic ok;
    act = {ir_write, pc_write, i_or_d, reg2loc, AluSrc, memtoReg,
           Branch, CondCheck, memRead, memWrite, regWrite};
    ok = (state_o === st) && (act === str) && (exc === ex) && (exc_code === code) &&
         (!chk_alu || (AluControl === alu));
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual state=%0d strobes=%b exc=%b code=%b alu=%b ; required state=%0d strobes=%b exc=%b code=%b alu=%b",
               name, state_o, act, exc, exc_code, AluControl, st, str, ex, code,
               chk_alu ? alu : AluControl);
    end
  endtask

  // driver: apply inputs for one cycle, sample at negedge, advance past posedge
  task automatic cyc(input string name, input logic r, input logic m, input logic [10:0] i,
                     input logic [2:0] st, input logic [10:0] str, input logic ex,
                     input logic [1:0] code, input logic chk_alu = 1'b0,
                     input logic [3:0] alu = 4'b0000);
    reset     = r;
    mem_ready = m;
    instr     = i;
    @(negedge clk);
    check(name, st, str, ex, code, chk_alu, alu);
    @(posedge clk);
    #1;
  endtask

  // watchdog on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rst rdy ins   state strobes ex code chk alu
    tbl[0]  = '{1'b1, 1'b1, I_ADD,  SF, NONE,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 1'b1, I_ADD,  SF, FRDY,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[2]  = '{1'b0, 1'b1, I_ADD,  SD, NONE,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[3]  = '{1'b0, 1'b0, I_ADD,  SE, NONE,          1'b0, 2'b00, 1'b1, 4'b0010};
    tbl[4]  = '{1'b0, 1'b0, I_ADD,  SW, B_RW,          1'b0, 2'b00, 1'b1, 4'b0010};
    tbl[5]  = '{1'b0, 1'b1, I_CBZ,  SF, FRDY,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[6]  = '{1'b0, 1'b1, I_CBZ,  SD, B_R2L,         1'b0, 2'b00, 1'b1, 4'b0010};
    tbl[7]  = '{1'b0, 1'b1, I_CBZ,  SE, B_BR,          1'b0, 2'b00, 1'b1, 4'b0111};
    tbl[8]  = '{1'b0, 1'b1, I_BC,   SF, FRDY,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[9]  = '{1'b0, 1'b1, I_BC,   SD, NONE,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[10] = '{1'b0, 1'b1, I_BC,   SE, B_BR | B_CC,   1'b0, 2'b00, 1'b1, 4'b0111};
    tbl[11] = '{1'b0, 1'b0, I_LDUR, SF, B_MR,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[12] = '{1'b0, 1'b0, I_LDUR, SF, B_MR,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[13] = '{1'b0, 1'b0, I_LDUR, SF, B_MR,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[14] = '{1'b0, 1'b1, I_LDUR, SF, FRDY,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[15] = '{1'b0, 1'b1, I_LDUR, SD, NONE,          1'b0, 2'b00, 1'b1, 4'b0111};
    tbl[16] = '{1'b0, 1'b1, I_LDUR, SE, B_ASRC,        1'b0, 2'b00, 1'b1, 4'b0010};
    tbl[17] = '{1'b0, 1'b0, I_LDUR, SM, B_IOD | B_MR,  1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[18] = '{1'b0, 1'b1, I_LDUR, SM, B_IOD | B_MR,  1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[19] = '{1'b0, 1'b1, I_LDUR, SW, B_RW | B_M2R,  1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[20] = '{1'b0, 1'b1, I_STUR, SF, FRDY,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[21] = '{1'b0, 1'b1, I_STUR, SD, B_R2L,         1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[22] = '{1'b0, 1'b1, I_STUR, SE, B_ASRC,        1'b0, 2'b00, 1'b1, 4'b0010};
    tbl[23] = '{1'b0, 1'b1, I_STUR, SM, B_IOD | B_MW,  1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[24] = '{1'b0, 1'b0, I_SUB,  SF, B_MR,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[25] = '{1'b0, 1'b1, I_SUB,  SF, FRDY,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[26] = '{1'b0, 1'b1, I_SUB,  SD, NONE,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[27] = '{1'b0, 1'b1, I_SUB,  SE, NONE,          1'b0, 2'b00, 1'b1, 4'b0110};
    tbl[28] = '{1'b0, 1'b1, I_SUB,  SW, B_RW,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[29] = '{1'b0, 1'b1, I_AND,  SF, FRDY,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[30] = '{1'b0, 1'b1, I_AND,  SD, NONE,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[31] = '{1'b0, 1'b1, I_AND,  SE, NONE,          1'b0, 2'b00, 1'b1, 4'b0000};
    tbl[32] = '{1'b0, 1'b1, I_AND,  SW, B_RW,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[33] = '{1'b0, 1'b1, I_ORR,  SF, FRDY,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[34] = '{1'b0, 1'b1, I_ORR,  SD, NONE,          1'b0, 2'b00, 1'b0, 4'b0000};
    tbl[35] = '{1'b0, 1'b1, I_ORR,  SE, NONE,          1'b0, 2'b00, 1'b1, 4'b0001};
    tbl[36] = '{1'b0, 1'b1, I_ORR,  SW, B_RW,          1'b0, 2'b00, 1'b1, 4'b0001};

    // initial reset edge
    reset     = 1'b1;
    mem_ready = 1'b0;
    instr     = I_ADD;
    @(posedge clk);
    #1;

    // table-driven walk of every instruction class
    for (int v = 0; v < NV; v++) begin
      cyc($sformatf("vec%0d", v), tbl[v].rst, tbl[v].rdy, tbl[v].ins, tbl[v].st,
          tbl[v].str, tbl[v].ex, tbl[v].code, tbl[v].chk_alu, tbl[v].alu);
    end

    // STUR data timeout: 15 waiting cycles in MEM raise code 11
    cyc("st_to_rst", 1'b1, 1'b0, I_STUR, SF, NONE, 1'b0, 2'b00);
    cyc("st_to_f",   1'b0, 1'b1, I_STUR, SF, FRDY, 1'b0, 2'b00);
    cyc("st_to_d",   1'b0, 1'b1, I_STUR, SD, B_R2L, 1'b0, 2'b00);
    cyc("st_to_e",   1'b0, 1'b1, I_STUR, SE, B_ASRC, 1'b0, 2'b00, 1'b1, 4'b0010);
    for (int k = 0; k < 15; k++)
      cyc($sformatf("st_to_mem%0d", k), 1'b0, 1'b0, I_STUR, SM, B_IOD | B_MW, 1'b0, 2'b00);
    for (int k = 0; k < 3; k++)
      cyc($sformatf("st_to_exc%0d", k), 1'b0, 1'b1, I_STUR, SX, NONE, 1'b1, 2'b11);

    // STUR with mem_ready arriving on the 15th MEM cycle completes normally
    cyc("st_ok_rst", 1'b1, 1'b0, I_STUR, SX, NONE, 1'b1, 2'b11);
    cyc("st_ok_f",   1'b0, 1'b1, I_STUR, SF, FRDY, 1'b0, 2'b00);
    cyc("st_ok_d",   1'b0, 1'b1, I_STUR, SD, B_R2L, 1'b0, 2'b00);
    cyc("st_ok_e",   1'b0, 1'b1, I_STUR, SE, B_ASRC, 1'b0, 2'b00);
    for (int k = 0; k < 14; k++)
      cyc($sformatf("st_ok_mem%0d", k), 1'b0, 1'b0, I_STUR, SM, B_IOD | B_MW, 1'b0, 2'b00);
    cyc("st_ok_mem14", 1'b0, 1'b1, I_STUR, SM, B_IOD | B_MW, 1'b0, 2'b00);
    cyc("st_ok_next",  1'b0, 1'b0, I_STUR, SF, B_MR, 1'b0, 2'b00);

    // fetch timeout: 15 waiting cycles in FETCH raise code 10
    cyc("f_to_rst", 1'b1, 1'b0, I_ADD, SF, NONE, 1'b0, 2'b00);
    for (int k = 0; k < 15; k++)
      cyc($sformatf("f_to_wait%0d", k), 1'b0, 1'b0, I_ADD, SF, B_MR, 1'b0, 2'b00);
    cyc("f_to_exc", 1'b0, 1'b1, I_ADD, SX, NONE, 1'b1, 2'b10);

    // invalid opcode traps and stays sticky regardless of inputs
    cyc("inv_rst", 1'b1, 1'b0, I_BAD, SX, NONE, 1'b1, 2'b10);
    cyc("inv_f",   1'b0, 1'b1, I_BAD, SF, FRDY, 1'b0, 2'b00);
    cyc("inv_d",   1'b0, 1'b1, I_BAD, SD, NONE, 1'b0, 2'b00);
    for (int k = 0; k < 20; k++)
      cyc($sformatf("inv_sticky%0d", k), 1'b0, 1'($urandom_range(0, 1)),
          11'($urandom_range(0, 2047)), SX, NONE, 1'b1, 2'b01);
    cyc("inv_rst2",  1'b1, 1'b1, I_ADD, SX, NONE, 1'b1, 2'b01);
    cyc("inv_after", 1'b0, 1'b0, I_ADD, SF, B_MR, 1'b0, 2'b00);

    // reset during a pending LDUR MEM: no strobes in the reset cycle,
    // FETCH afterwards, and regWrite never appears for that load
    mon_en = 1'b1;
    cyc("ld_rst_f",   1'b0, 1'b1, I_LDUR, SF, FRDY, 1'b0, 2'b00);
    cyc("ld_rst_d",   1'b0, 1'b1, I_LDUR, SD, NONE, 1'b0, 2'b00);
    cyc("ld_rst_e",   1'b0, 1'b1, I_LDUR, SE, B_ASRC, 1'b0, 2'b00, 1'b1, 4'b0010);
    cyc("ld_rst_m0",  1'b0, 1'b0, I_LDUR, SM, B_IOD | B_MR, 1'b0, 2'b00);
    cyc("ld_rst_m1",  1'b0, 1'b0, I_LDUR, SM, B_IOD | B_MR, 1'b0, 2'b00);
    cyc("ld_rst_hit", 1'b1, 1'b1, I_LDUR, SM, NONE, 1'b0, 2'b00);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("ld_rst_after%0d", k), 1'b0, 1'b0, I_LDUR, SF, B_MR, 1'b0, 2'b00);
    mon_en = 1'b0;
    total++;
    if (rw_seen) begin
      bad++;
      $display("FAIL ld_rst_no_regwrite: actual regWrite seen=1 required=0");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
